// File: rtl/mbist_pkg.sv
// Shared types for the March C- memory BIST controller: FSM states, element
// indices and the per-element operation table.
package mbist_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } state_e;

    localparam logic [2:0] E0 = 3'd0;
    localparam logic [2:0] E1 = 3'd1;
    localparam logic [2:0] E2 = 3'd2;
    localparam logic [2:0] E3 = 3'd3;
    localparam logic [2:0] E4 = 3'd4;
    localparam logic [2:0] E5 = 3'd5;

    typedef struct packed {
        logic down;      // address order: 1 = CAPACITY..0
        logic rd_exp;    // expected read word, replicated across the data width
        logic wr_data;   // write word, replicated across the data width
        logic has_read;
        logic has_write;
    } elem_cfg_t;

    function automatic elem_cfg_t elem_cfg(input logic [2:0] elem);
        elem_cfg_t cfg;
        case (elem)
            E0:      cfg = '{down: 1'b0, rd_exp: 1'b0, wr_data: 1'b0, has_read: 1'b0, has_write: 1'b1};
            E1:      cfg = '{down: 1'b0, rd_exp: 1'b0, wr_data: 1'b1, has_read: 1'b1, has_write: 1'b1};
            E2:      cfg = '{down: 1'b0, rd_exp: 1'b1, wr_data: 1'b0, has_read: 1'b1, has_write: 1'b1};
            E3:      cfg = '{down: 1'b1, rd_exp: 1'b0, wr_data: 1'b1, has_read: 1'b1, has_write: 1'b1};
            E4:      cfg = '{down: 1'b1, rd_exp: 1'b1, wr_data: 1'b0, has_read: 1'b1, has_write: 1'b1};
            default: cfg = '{down: 1'b1, rd_exp: 1'b0, wr_data: 1'b0, has_read: 1'b1, has_write: 1'b0};
        endcase
        return cfg;
    endfunction

endpackage

// File: rtl/mbist_march_ctrl_if.sv
// Memory-side bus between the BIST controller (master) and the memory under test.
interface mbist_march_ctrl_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4
);
    logic                  write_read;
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (output write_read, output address, output wdata, input rdata);
    modport slave  (input write_read, input address, input wdata, output rdata);
endinterface

// File: rtl/mbist_rd_compare.sv
// Two-stage expected-data pipeline matching the memory read latency, with
// comparison against returned data and capture of the first mismatch only.
module mbist_rd_compare #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear_i,
    input  logic                  rd_valid_i,
    input  logic [DATA_WIDTH-1:0] rd_exp_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    input  logic [2:0]            rd_elem_i,
    input  logic [DATA_WIDTH-1:0] rdata_i,
    output logic                  mismatch_o,
    output logic                  seen_o,
    output logic [ADDR_WIDTH-1:0] fail_addr_o,
    output logic [2:0]            fail_elem_o,
    output logic [DATA_WIDTH-1:0] fail_data_o
);

    logic [1:0]                 vld_q, vld_d;
    logic [1:0][DATA_WIDTH-1:0] exp_q, exp_d;
    logic [1:0][ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [1:0][2:0]            elem_q, elem_d;
    logic                       seen_q, seen_d;
    logic [ADDR_WIDTH-1:0]      fail_addr_q, fail_addr_d;
    logic [2:0]                 fail_elem_q, fail_elem_d;
    logic [DATA_WIDTH-1:0]      fail_data_q, fail_data_d;

    always_comb begin
        vld_d  = {vld_q[0], rd_valid_i};
        exp_d  = {exp_q[0], rd_exp_i};
        addr_d = {addr_q[0], rd_addr_i};
        elem_d = {elem_q[0], rd_elem_i};

        mismatch_o = vld_q[1] & (rdata_i != exp_q[1]);

        seen_d      = seen_q;
        fail_addr_d = fail_addr_q;
        fail_elem_d = fail_elem_q;
        fail_data_d = fail_data_q;
        if (clear_i) begin
            seen_d      = 1'b0;
            fail_addr_d = '0;
            fail_elem_d = '0;
            fail_data_d = '0;
        end else if (mismatch_o && !seen_q) begin
            seen_d      = 1'b1;
            fail_addr_d = addr_q[1];
            fail_elem_d = elem_q[1];
            fail_data_d = rdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q       <= '0;
            exp_q       <= '0;
            addr_q      <= '0;
            elem_q      <= '0;
            seen_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_elem_q <= '0;
            fail_data_q <= '0;
        end else begin
            vld_q       <= vld_d;
            exp_q       <= exp_d;
            addr_q      <= addr_d;
            elem_q      <= elem_d;
            seen_q      <= seen_d;
            fail_addr_q <= fail_addr_d;
            fail_elem_q <= fail_elem_d;
            fail_data_q <= fail_data_d;
        end
    end

    assign seen_o      = seen_q;
    assign fail_addr_o = fail_addr_q;
    assign fail_elem_o = fail_elem_q;
    assign fail_data_o = fail_data_q;

endmodule

// File: rtl/mbist_march_ctrl.sv
// March C- memory BIST controller: sequences one memory op per cycle over six
// elements and reports pass/fail with first-failure address, element and data.
module mbist_march_ctrl
    import mbist_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned CAPACITY   = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic                  fail,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [2:0]            fail_elem,
    output logic [DATA_WIDTH-1:0] fail_data,
    mbist_march_ctrl_if.master    mem
);

    localparam logic [ADDR_WIDTH-1:0] AddrMax = ADDR_WIDTH'(CAPACITY);

    state_e                state_q, state_d;
    logic [2:0]            elem_q, elem_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  phase_q, phase_d;  // 0 = read half, 1 = write half of r/w pair
    logic                  drain_q, drain_d;

    elem_cfg_t             cur_cfg, adv_cfg, nxt_cfg;
    logic                  cur_write, last_in_addr, last_addr, last_op;
    logic [2:0]            adv_elem;
    logic [ADDR_WIDTH-1:0] adv_addr;
    logic                  adv_phase;
    logic                  start_ok, issue, run_next, nxt_write;
    logic                  mismatch, mismatch_seen;

    always_comb begin
        cur_cfg      = elem_cfg(elem_q);
        cur_write    = cur_cfg.has_write & (~cur_cfg.has_read | phase_q);
        last_in_addr = ~(cur_cfg.has_read & cur_cfg.has_write) | phase_q;
        last_addr    = cur_cfg.down ? (addr_q == '0) : (addr_q == AddrMax);
        last_op      = (elem_q == E5) & last_addr & last_in_addr;

        adv_elem  = (last_in_addr & last_addr & ~last_op) ? elem_q + 3'd1 : elem_q;
        adv_cfg   = elem_cfg(adv_elem);
        adv_addr  = addr_q;
        adv_phase = 1'b0;
        if (!last_in_addr) begin
            adv_phase = 1'b1;
        end else if (!last_addr) begin
            adv_addr = cur_cfg.down ? addr_q - ADDR_WIDTH'(1) : addr_q + ADDR_WIDTH'(1);
        end else begin
            // element boundary: restart from the new element's first address, no wrap
            adv_addr = adv_cfg.down ? AddrMax : '0;
        end
    end

    always_comb begin
        state_d  = state_q;
        elem_d   = elem_q;
        addr_d   = addr_q;
        phase_d  = phase_q;
        drain_d  = drain_q;
        start_ok = 1'b0;
        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    start_ok = 1'b1;
                    state_d  = StRun;
                    elem_d   = E0;
                    addr_d   = '0;
                    phase_d  = 1'b0;
                end
            end
            StRun: begin
                elem_d  = adv_elem;
                addr_d  = adv_addr;
                phase_d = adv_phase;
                if (last_op || mismatch) begin
                    state_d = StDrain;
                    drain_d = 1'b0;
                end
            end
            StDrain: begin
                drain_d = 1'b1;
                if (drain_q) state_d = StDone;
            end
            default: state_d = StIdle;
        endcase

        // wdata is registered once inside the memory, so present the next op's data now
        issue     = (state_q == StRun);
        run_next  = start_ok | (issue & ~last_op);
        nxt_cfg   = elem_cfg(elem_d);
        nxt_write = nxt_cfg.has_write & (~nxt_cfg.has_read | phase_d);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            elem_q  <= E0;
            addr_q  <= '0;
            phase_q <= 1'b0;
            drain_q <= 1'b0;
        end else begin
            state_q <= state_d;
            elem_q  <= elem_d;
            addr_q  <= addr_d;
            phase_q <= phase_d;
            drain_q <= drain_d;
        end
    end

    assign mem.write_read = issue & cur_write;
    assign mem.address    = issue ? addr_q : '0;
    assign mem.wdata      = (run_next & nxt_write) ? {DATA_WIDTH{nxt_cfg.wr_data}} : '0;

    assign busy = (state_q == StRun) | (state_q == StDrain);
    assign done = (state_q == StDone);
    assign pass = done & ~mismatch_seen;
    assign fail = done & mismatch_seen;

    mbist_rd_compare #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_rd_compare (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear_i     (start_ok),
        .rd_valid_i  (issue & ~cur_write),
        .rd_exp_i    ({DATA_WIDTH{cur_cfg.rd_exp}}),
        .rd_addr_i   (addr_q),
        .rd_elem_i   (elem_q),
        .rdata_i     (mem.rdata),
        .mismatch_o  (mismatch),
        .seen_o      (mismatch_seen),
        .fail_addr_o (fail_addr),
        .fail_elem_o (fail_elem),
        .fail_data_o (fail_data)
    );

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Self-checking bench: faulty-memory model with 2-cycle read latency and a
// registered write-data stage, checked against a March C- reference model.
module tb_mbist_march_ctrl;

    localparam int DW   = 8;
    localparam int AW   = 4;
    localparam int CAP  = 15;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          busy, done, pass, fail;
    logic [AW-1:0] fail_addr;
    logic [2:0]    fail_elem;
    logic [DW-1:0] fail_data;

    mbist_march_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) mif ();

    mbist_march_ctrl #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .CAPACITY   (CAP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .fail      (fail),
        .fail_addr (fail_addr),
        .fail_elem (fail_elem),
        .fail_data (fail_data),
        .mem       (mif)
    );

    always #5 clk = ~clk;

    typedef logic [DW-1:0] mem_t [CAP+1];
    typedef struct packed {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [2:0]    elem;
    } op_t;

    mem_t          mem;
    logic [DW-1:0] wdata_reg, rd_p1, rd_p2;
    int            fault_kind;  // 0 none, 1 stuck-at, 2 neighbourhood pattern
    int            fa, fb;
    logic          fv;
    op_t           exp_ops[$];
    int            n_tests = 0;
    int            n_fail  = 0;

    function automatic logic [DW-1:0] fault_read(input mem_t m, input int a);
        logic [DW-1:0] v;
        v = m[a];
        if (fault_kind == 1 && a == fa) v[fb] = fv;
        if (fault_kind == 2 && a == 7 && {m[6][1], m[8][1], m[5][1], m[9][1]} == 4'b1010)
            v[1] = ~v[1];
        return v;
    endfunction

    always @(posedge clk) begin
        wdata_reg <= mif.wdata;
        rd_p1     <= fault_read(mem, int'(mif.address));
        rd_p2     <= rd_p1;
        if (mif.write_read) mem[mif.address] <= wdata_reg;
    end
    assign mif.rdata = rd_p2;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // March C- from its textual definition, then replayed on an abstract memory
    task automatic build_model(output int nops, output bit efail, output logic [AW-1:0] eaddr,
                               output logic [2:0] eelem, output logic [DW-1:0] edata,
                               output logic [DW-1:0] eword);
        bit   down [6];
        int   rv [6];
        int   wv [6];
        mem_t m;
        logic [DW-1:0] obs;
        down = '{0, 0, 0, 1, 1, 1};
        rv   = '{-1, 0, 1, 0, 1, 0};
        wv   = '{0, 1, 0, 1, 0, -1};
        m    = mem;
        exp_ops.delete();
        for (int e = 0; e < 6; e++) begin
            for (int k = 0; k <= CAP; k++) begin
                int a;
                a = down[e] ? CAP - k : k;
                if (rv[e] >= 0) exp_ops.push_back('{1'b0, AW'(a), (rv[e] == 1) ? '1 : '0, 3'(e)});
                if (wv[e] >= 0) exp_ops.push_back('{1'b1, AW'(a), (wv[e] == 1) ? '1 : '0, 3'(e)});
            end
        end
        nops = exp_ops.size();
        efail = 0; eaddr = '0; eelem = '0; edata = '0; eword = '0;
        for (int i = 0; i < exp_ops.size(); i++) begin
            if (exp_ops[i].wr) begin
                m[exp_ops[i].addr] = exp_ops[i].data;
            end else begin
                obs = fault_read(m, int'(exp_ops[i].addr));
                if (obs !== exp_ops[i].data) begin
                    efail = 1; eaddr = exp_ops[i].addr; eelem = exp_ops[i].elem;
                    edata = obs; eword = exp_ops[i].data;
                    // detected two cycles after the read; ops stop after that cycle
                    nops  = (i + 3 < nops) ? i + 3 : nops;
                    break;
                end
            end
        end
    endtask

    task automatic run_test(input int rst_at, input int pulse_at, input bit hold);
        int nops, c, w;
        bit efail;
        logic [AW-1:0] eaddr;
        logic [2:0] eelem;
        logic [DW-1:0] edata, eword;
        build_model(nops, efail, eaddr, eelem, edata, eword);
        for (w = 1; w <= 5; w++) begin
            @(negedge clk);
            start = hold;
            if (busy) break;
        end
        chk("start_latency", w, 1);
        if (w > 5) return;
        c = 0;
        while (busy && c < 400) begin
            if (c < nops) begin
                chk("op", 32'({mif.write_read, mif.address}), 32'({exp_ops[c].wr, exp_ops[c].addr}));
                if (mif.write_read) chk("wdata_lead", 32'(wdata_reg), 32'(exp_ops[c].data));
            end else begin
                chk("drain_idle", 32'({mif.write_read, mif.address, mif.wdata}), 32'd0);
            end
            if (c == rst_at) begin
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                chk("rst_write_read", 32'(mif.write_read), 32'd0);
                chk("rst_busy", 32'(busy), 32'd0);
                chk("rst_done", 32'(done), 32'd0);
                return;
            end
            start = (c == pulse_at) ? 1'b1 : hold;
            c++;
            @(negedge clk);
        end
        start = hold;
        chk("busy_cycles", c, nops + 2);
        chk("done", 32'(done), 32'd1);
        chk("pass", 32'(pass), 32'(!efail));
        chk("fail", 32'(fail), 32'(efail));
        if (efail) begin
            chk("fail_addr", 32'(fail_addr), 32'(eaddr));
            chk("fail_elem", 32'(fail_elem), 32'(eelem));
            chk("fail_data", 32'(fail_data), 32'(edata));
        end
        if (fault_kind == 2) chk("npsf_bitdiff", 32'(fail_data ^ eword), 32'h02);
    endtask

    initial begin
        fault_kind = 0; fa = 0; fb = 0; fv = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy0", 32'(busy), 32'd0);
        chk("rst_flags", 32'({done, pass, fail}), 32'd0);
        chk("rst_bus", 32'({mif.write_read, mif.address, mif.wdata}), 32'd0);
        chk("rst_fail_info", 32'({fail_addr, fail_elem, fail_data}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // fault-free run, then done held while idle
        start = 1'b1;
        run_test(-1, -1, 1'b0);
        repeat (4) @(negedge clk);
        chk("done_hold", 32'({done, pass}), 32'b11);

        // bit 3 of address 5 stuck at 1
        fault_kind = 1; fa = 5; fb = 3; fv = 1'b1;
        start = 1'b1;
        run_test(-1, -1, 1'b0);
        chk("saf_summary", 32'({fail, fail_elem, fail_addr, fail_data}), 32'({1'b1, 3'd1, 4'd5, 8'h08}));

        // neighbourhood pattern fault on victim 7
        fault_kind = 2;
        start = 1'b1;
        run_test(-1, -1, 1'b0);
        chk("npsf_addr", 32'(fail_addr), 32'd7);

        // reset at op 50, then a clean full run
        fault_kind = 0;
        start = 1'b1;
        run_test(50, -1, 1'b0);
        repeat (3) @(negedge clk);
        chk("post_rst_done", 32'({done, busy}), 32'd0);
        start = 1'b1;
        run_test(-1, -1, 1'b0);

        // start pulse mid-run is ignored
        start = 1'b1;
        run_test(-1, 20, 1'b0);

        // start held high restarts at DONE
        start = 1'b1;
        run_test(-1, -1, 1'b1);
        run_test(-1, -1, 1'b0);

        for (int r = 0; r < 8; r++) begin
            fault_kind = int'($urandom_range(0, 2));
            fa = int'($urandom_range(0, CAP));
            fb = int'($urandom_range(0, DW - 1));
            fv = 1'($urandom_range(0, 1));
            repeat ($urandom_range(1, 4)) @(negedge clk);
            start = 1'b1;
            run_test(-1, ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 100)) : -1, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
